// File: rtl/cmd_arb_pkg.sv
// rtl/cmd_arb_pkg.sv - shared types and helpers for the command stream arbiter
package cmd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam logic [7:0] ABORT_BYTE_DEFAULT = 8'hFF;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cmd_arb_rr_pick.sv
// rtl/cmd_arb_rr_pick.sv - round-robin priority picker, search starts one past rr_ptr_i
module cmd_arb_rr_pick
    import cmd_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] rr_ptr_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] index_o
);

    localparam int IW = $clog2(N);

    int cur;

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cur     = int'(rr_ptr_i);
        for (int k = 0; k < N; k++) begin
            cur = rr_next(cur, N);
            if (!found_o && valid_i[IW'(cur)]) begin
                found_o = 1'b1;
                index_o = IW'(cur);
            end
        end
    end

endmodule

// File: rtl/cmd_axis_arbiter.sv
// rtl/cmd_axis_arbiter.sv - packet-locked round-robin arbiter with stall watchdog onto one 8-bit stream
// Optional per-source packet / abort counters under CMD_ARB_STATS_EN.
module cmd_axis_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int         NUM_SRC        = 2,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] ABORT_BYTE     = ABORT_BYTE_DEFAULT
) (
    input  logic                       axi_tclk,
    input  logic                       axi_tresetn,
    input  logic                       enable,
    input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       abort_pulse
`ifdef CMD_ARB_STATS_EN
    ,
    output logic [32*NUM_SRC-1:0]      pkt_count,
    output logic [15:0]                abort_count
`endif
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic               g_valid, g_last;
    logic [7:0]         g_data;
    logic [NUM_SRC-1:0] grant_oh;

    cmd_arb_rr_pick #(.N(NUM_SRC)) u_pick (
        .valid_i  (s_axis_tvalid),
        .rr_ptr_i (rr_q),
        .found_o  (pick_found),
        .index_o  (pick_idx)
    );

    always_comb begin
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = 8'h00;
        grant_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IW'(i)) begin
                g_valid     = s_axis_tvalid[i];
                g_last      = s_axis_tlast[i];
                g_data      = s_axis_tdata[8*i +: 8];
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        abort_pulse   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant_d = pick_idx;
                    rr_d    = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tdata  = g_data;
                m_axis_tvalid = g_valid;
                m_axis_tlast  = g_last;
                s_axis_tready = grant_oh & {NUM_SRC{m_axis_tready}};
                // Backpressure with data pending holds the watchdog; only a silent source ages it.
                if (g_valid) begin
                    if (m_axis_tready) begin
                        cnt_d = '0;
                        if (g_last) state_d = ST_IDLE;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ABORT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                m_axis_tdata  = ABORT_BYTE;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    abort_pulse = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                s_axis_tready = grant_oh;
                if (g_valid && g_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef CMD_ARB_STATS_EN
    always_ff @(posedge axi_tclk) begin
        if (!axi_tresetn) begin
            pkt_count   <= '0;
            abort_count <= '0;
        end else begin
            if (abort_pulse) abort_count <= abort_count + 16'd1;
            if (state_q == ST_PASS && g_valid && g_last && m_axis_tready) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == IW'(i)) pkt_count[32*i +: 32] <= pkt_count[32*i +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_axis_arbiter.sv
// tb/tb_cmd_axis_arbiter.sv - self-checking bench for cmd_axis_arbiter
module tb_cmd_axis_arbiter;

    localparam int NS = 2;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] d;
        bit         last;
        int         gap;
    } beat_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [8*NS-1:0] s_tdata = '0;
    logic [NS-1:0]   s_tvalid = '0;
    logic [NS-1:0]   s_tlast = '0;
    logic [NS-1:0]   s_tready;
    logic [7:0]      m_tdata;
    logic            m_tvalid, m_tlast;
    logic            m_tready;
    logic [0:0]      grant_id;
    logic            busy, abort_pulse;

    cmd_axis_arbiter #(.NUM_SRC(NS), .TIMEOUT_CYCLES(TO), .ABORT_BYTE(8'hFF)) dut (
        .axi_tclk      (clk),
        .axi_tresetn   (resetn),
        .enable        (enable),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_id      (grant_id),
        .busy          (busy),
        .abort_pulse   (abort_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Source drivers: each beat waits 'gap' cycles with tvalid low, then holds until accepted.
    beat_t         srcq[NS][$];
    int            wait_left[NS];
    bit            loaded[NS];
    logic [NS-1:0] drv_hs;

    always @(posedge clk) begin
        drv_hs = s_tvalid & s_tready;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (!resetn) begin
                srcq[i].delete();
                loaded[i] = 0;
            end else if (drv_hs[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                loaded[i] = 0;
            end
            if (srcq[i].size() > 0 && !loaded[i]) begin
                wait_left[i] = srcq[i][0].gap;
                loaded[i]    = 1;
            end
            if (srcq[i].size() > 0 && wait_left[i] == 0) begin
                s_tvalid[i]       = 1'b1;
                s_tlast[i]        = srcq[i][0].last;
                s_tdata[8*i +: 8] = srcq[i][0].d;
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tlast[i]        = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                if (wait_left[i] > 0) wait_left[i]--;
            end
        end
    end

    // Reference model: who owns the output, whether it is aborting/draining, how long it has stalled.
    int mo, mlast, mgrant, mstall, cyc;
    bit mab, mdr, started;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!resetn) begin
            mo = -1; mlast = NS - 1; mgrant = 0; mstall = 0; mab = 0; mdr = 0;
        end else if (mo < 0) begin
            if (enable) begin
                for (int k = 1; k <= NS; k++) begin
                    int c;
                    c = (mlast + k) % NS;
                    if (mo < 0 && s_tvalid[c]) mo = c;
                end
                if (mo >= 0) begin
                    mlast = mo; mgrant = mo; mstall = 0;
                end
            end
        end else if (mab) begin
            if (m_tready) begin mab = 0; mdr = 1; end
        end else if (mdr) begin
            if (s_tvalid[mo] && s_tlast[mo]) begin mdr = 0; mo = -1; end
        end else if (s_tvalid[mo]) begin
            if (m_tready) begin
                mstall = 0;
                if (s_tlast[mo]) mo = -1;
            end
        end else begin
            mstall++;
            if (mstall == TO) mab = 1;
        end
    end

    logic [7:0]    e_td;
    logic          e_tv, e_tl, e_busy, e_pulse;
    logic [NS-1:0] e_rdy;

    always @(negedge clk) begin
        if (started) begin
            e_td = 8'h00; e_tv = 0; e_tl = 0; e_rdy = '0; e_pulse = 0; e_busy = (mo >= 0);
            if (mo >= 0) begin
                if (mab) begin
                    e_tv = 1; e_td = 8'hFF; e_tl = 1; e_pulse = m_tready;
                end else if (mdr) begin
                    e_rdy[mo] = 1'b1;
                end else begin
                    e_tv = s_tvalid[mo]; e_tl = s_tlast[mo]; e_td = s_tdata[8*mo +: 8];
                    e_rdy[mo] = m_tready;
                end
            end
            chk("m_tvalid", m_tvalid, e_tv);
            chk("m_tdata", m_tdata, e_td);
            chk("m_tlast", m_tlast, e_tl);
            chk("s_tready", s_tready, e_rdy);
            chk("busy", busy, e_busy);
            chk("abort_pulse", abort_pulse, e_pulse);
            chk("grant_id", grant_id, mgrant);
        end
    end

    logic [8:0] obs[$];
    int         obs_cyc[$];
    int         npulse = 0;

    always @(negedge clk) begin
        if (resetn && m_tvalid && m_tready) begin
            obs.push_back({m_tlast, m_tdata});
            obs_cyc.push_back(cyc);
        end
        if (resetn && abort_pulse) npulse++;
    end

    logic [8:0] expq[$];
    int         base, p0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int s, input logic [7:0] d, input bit l, input int g);
        beat_t b;
        b.d = d; b.last = l; b.gap = g;
        srcq[s].push_back(b);
    endtask

    task automatic wait_beats(input int n, input string nm);
        int b = 0;
        while (obs.size() < n && b < 5000) begin tick(); b++; end
        chk({nm, "_beat_wait"}, obs.size() >= n, 1);
    endtask

    task automatic wait_idle(input string nm);
        int b = 0;
        while (busy && b < 5000) begin tick(); b++; end
        chk({nm, "_idle_wait"}, busy, 0);
    endtask

    task automatic chk_stream(input string nm);
        chk({nm, "_len"}, obs.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < obs.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), obs[base + i], expq[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        resetn = 0; enable = 1; m_tready = 1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_pulse", abort_pulse, 0);

        // Both sources ready from reset release: src0 first, one bubble, then src1
        base = obs.size(); p0 = npulse;
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h10 + 8'(i), i == 3, 0);
            push(1, 8'h20 + 8'(i), i == 3, 0);
        end
        resetn = 1;
        wait_beats(base + 8, "s1");
        wait_idle("s1");
        expq = '{9'h010, 9'h011, 9'h012, 9'h113, 9'h020, 9'h021, 9'h022, 9'h123};
        chk_stream("s1");
        chk("s1_bubble", obs_cyc[base + 4] - obs_cyc[base + 3], 2);
        chk("s1_grant", grant_id, 1);

        // Src1 alone three times, then both: rr pointer at 1 hands src0 the next turn
        base = obs.size();
        for (int p = 0; p < 3; p++) begin
            push(1, 8'h31 + 8'(2*p), 0, 0);
            push(1, 8'h32 + 8'(2*p), 1, 0);
        end
        wait_beats(base + 6, "s2a");
        wait_idle("s2a");
        push(0, 8'h3A, 0, 0); push(0, 8'h3B, 1, 0);
        push(1, 8'h3C, 0, 0); push(1, 8'h3D, 1, 0);
        wait_beats(base + 10, "s2");
        wait_idle("s2");
        expq = '{9'h031, 9'h132, 9'h033, 9'h134, 9'h035, 9'h136, 9'h03A, 9'h13B, 9'h03C, 9'h13D};
        chk_stream("s2");

        // Long downstream backpressure with data pending must never abort
        base = obs.size();
        for (int i = 0; i < 4; i++) push(0, 8'h40 + 8'(i), i == 3, 0);
        wait_beats(base + 2, "s3a");
        m_tready = 0;
        repeat (2000) tick();
        chk("s3_held_busy", busy, 1);
        m_tready = 1;
        wait_beats(base + 4, "s3");
        wait_idle("s3");
        expq = '{9'h040, 9'h041, 9'h042, 9'h143};
        chk_stream("s3");
        chk("s3_no_abort", npulse - p0, 0);

        // Source stalls 16 cycles mid-packet: terminator, then the rest is swallowed
        base = obs.size(); p0 = npulse;
        push(0, 8'h50, 0, 0); push(0, 8'h51, 0, 0);
        push(0, 8'h52, 0, TO); push(0, 8'h53, 0, 0); push(0, 8'h54, 1, 0);
        wait_beats(base + 3, "s4");
        wait_idle("s4");
        repeat (2) tick();
        expq = '{9'h050, 9'h051, 9'h1FF};
        chk_stream("s4");
        chk("s4_pulses", npulse - p0, 1);
        chk("s4_abort_delay", obs_cyc[base + 2] - obs_cyc[base + 1], 17);
        chk("s4_drained", srcq[0].size(), 0);

        // enable drops mid-packet: packet finishes, no new grant until re-enabled
        base = obs.size();
        push(1, 8'h60, 0, 0); push(1, 8'h61, 0, 3); push(1, 8'h62, 0, 0); push(1, 8'h63, 1, 0);
        wait_beats(base + 1, "s5a");
        enable = 0;
        push(0, 8'h70, 0, 0); push(0, 8'h71, 1, 0);
        wait_beats(base + 4, "s5b");
        repeat (20) tick();
        chk("s5_parked_beats", obs.size() - base, 4);
        chk("s5_parked_busy", busy, 0);
        enable = 1;
        wait_beats(base + 6, "s5");
        wait_idle("s5");
        expq = '{9'h060, 9'h061, 9'h062, 9'h163, 9'h070, 9'h171};
        chk_stream("s5");

        // Reset mid-packet from src0: rr pointer returns to src0-first
        base = obs.size();
        for (int i = 0; i < 4; i++) push(0, 8'h80 + 8'(i), i == 3, 0);
        wait_beats(base + 1, "s6a");
        chk("s6_pre_busy", busy, 1);
        resetn = 0;
        tick();
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_tvalid", m_tvalid, 0);
        chk("s6_rst_tready", s_tready, 0);
        resetn = 1;
        base = obs.size();
        push(0, 8'h90, 0, 0); push(0, 8'h91, 1, 0);
        push(1, 8'hA0, 0, 0); push(1, 8'hA1, 1, 0);
        wait_beats(base + 4, "s6");
        wait_idle("s6");
        expq = '{9'h090, 9'h191, 9'h0A0, 9'h1A1};
        chk_stream("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
